// File: rtl/demux1xn_stream.sv
// demux1xn_stream: 1-to-N valid/ready stream demultiplexer, one output register per channel.
// Define DEMUX_CNT_EN to build the per-channel 16-bit transfer counters on o_cnt.
module demux1xn_stream #(
  parameter  int N_OUT = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        i_data,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_valid,
  output logic                i_ready,
  output logic [N_OUT*W-1:0]  y_data,
  output logic [N_OUT-1:0]    y_valid,
  input  logic [N_OUT-1:0]    y_ready,
  output logic                o_drop,
  output logic [N_OUT*16-1:0] o_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  logic             sel_in_range;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] ch_ready;
  logic [N_OUT-1:0] ch_write;
  logic             drop_reg;

  // Out-of-range selects are always accepted so a bad index can never stall the producer.
  assign sel_in_range = ({1'b0, i_sel} < (SEL_W + 1)'(N_OUT));
  assign i_ready      = sel_in_range ? |(sel_hit & ch_ready) : 1'b1;
  assign o_drop       = drop_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= i_valid & ~sel_in_range;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_ch
      ch_state_t    state_reg, state_next;
      logic [W-1:0] data_reg, data_next;

      assign sel_hit[gi]  = (i_sel == SEL_W'(gi));
      assign ch_ready[gi] = (state_reg == EMPTY) | y_ready[gi];
      assign ch_write[gi] = i_valid & sel_hit[gi] & ch_ready[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          data_reg  <= data_next;
        end
      end

      // A write during a consumer handshake keeps the channel FULL with the new word.
      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
          EMPTY:   if (ch_write[gi]) state_next = FULL;
          FULL:    if (!ch_write[gi] && y_ready[gi]) state_next = EMPTY;
          default: state_next = EMPTY;
        endcase
        if (ch_write[gi]) data_next = i_data;
      end

      assign y_valid[gi]        = (state_reg == FULL);
      assign y_data[gi*W +: W]  = data_reg;

`ifdef DEMUX_CNT_EN
      logic [15:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (y_valid[gi] && y_ready[gi]) cnt_next = cnt_reg + 16'd1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= 16'd0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign o_cnt[gi*16 +: 16] = cnt_reg;
`else
      assign o_cnt[gi*16 +: 16] = 16'd0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_demux1xn_stream.sv
// Directed bench for demux1xn_stream: a 4-channel instance and a 3-channel instance
// (the latter exercises out-of-range selects). Counter checks follow DEMUX_CNT_EN.
module tb_demux1xn_stream;

  logic        clk;
  logic        rst_n;

  logic [7:0]  i_data4;
  logic [1:0]  i_sel4;
  logic        i_valid4;
  logic        i_ready4;
  logic [31:0] y_data4;
  logic [3:0]  y_valid4;
  logic [3:0]  y_ready4;
  logic        o_drop4;
  logic [63:0] o_cnt4;

  logic [7:0]  i_data3;
  logic [1:0]  i_sel3;
  logic        i_valid3;
  logic        i_ready3;
  logic [23:0] y_data3;
  logic [2:0]  y_valid3;
  logic [2:0]  y_ready3;
  logic        o_drop3;
  logic [47:0] o_cnt3;

  int checks;
  int errors;

  demux1xn_stream #(.N_OUT(4), .W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data4), .i_sel(i_sel4), .i_valid(i_valid4), .i_ready(i_ready4),
    .y_data(y_data4), .y_valid(y_valid4), .y_ready(y_ready4),
    .o_drop(o_drop4), .o_cnt(o_cnt4)
  );

  demux1xn_stream #(.N_OUT(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data3), .i_sel(i_sel3), .i_valid(i_valid3), .i_ready(i_ready3),
    .y_data(y_data3), .y_valid(y_valid3), .y_ready(y_ready3),
    .o_drop(o_drop3), .o_cnt(o_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes and register checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [1:0] sel, input logic [7:0] data);
    i_valid4 = 1'b1;
    i_sel4   = sel;
    i_data4  = data;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (y_valid4 !== 4'b0000 || o_drop4 !== 1'b0 || i_ready4 !== 1'b1 || y_data4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_init: y_valid=%b y_data=%h o_drop=%b i_ready=%b, want 0000/0/0/1",
               y_valid4, y_data4, o_drop4, i_ready4);
    end
    rst_n = 1'b1;
    y_ready4 = 4'b0000;
    send4(2'd0, 8'h11);
    tick();
    send4(2'd1, 8'h22);
    tick();
    checks++;
    if (y_valid4 !== 4'b0011 || y_data4[15:0] !== 16'h2211) begin
      errors++;
      $display("FAIL reset_fill: y_valid=%b y_data=%h, want 0011 ....2211", y_valid4, y_data4);
    end
    send4(2'd0, 8'h33);
    checks++;
    if (i_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: i_ready=%b want 0", i_ready4);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_valid4 !== 4'b0000 || y_data4 !== 32'h0 || o_drop4 !== 1'b0 || i_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: y_valid=%b y_data=%h o_drop=%b i_ready=%b, want 0000/0/0/1",
               y_valid4, y_data4, o_drop4, i_ready4);
    end
    tick();
    i_valid4 = 1'b0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (y_valid4 !== 4'b0000 || i_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: y_valid=%b i_ready=%b, want 0000/1", y_valid4, i_ready4);
    end
    $display("test_reset done");
  endtask

  task automatic test_steering();
    logic [7:0] exp_data;
    y_ready4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_data = 8'hA0 + 8'(i);
      send4(2'(i), exp_data);
      checks++;
      if (i_ready4 !== 1'b1) begin
        errors++;
        $display("FAIL steer_ready%0d: i_ready=%b want 1", i, i_ready4);
      end
      tick();
      checks++;
      if (y_valid4 !== (4'b0001 << i) || y_data4[i*8 +: 8] !== exp_data) begin
        errors++;
        $display("FAIL steer_ch%0d: y_valid=%b data=%h, want %b %h",
                 i, y_valid4, y_data4[i*8 +: 8], 4'b0001 << i, exp_data);
      end
      $display("steer word %h -> ch%0d y_valid=%b", exp_data, i, y_valid4);
    end
    i_valid4 = 1'b0;
    tick();
    checks++;
    if (y_valid4 !== 4'b0000) begin
      errors++;
      $display("FAIL steer_drain: y_valid=%b want 0000", y_valid4);
    end
  endtask

  task automatic test_back_pressure();
    y_ready4 = 4'b1011;
    send4(2'd2, 8'h55);
    tick();
    checks++;
    if (y_valid4 !== 4'b0100 || y_data4[23:16] !== 8'h55) begin
      errors++;
      $display("FAIL bp_first: y_valid=%b data2=%h, want 0100 55", y_valid4, y_data4[23:16]);
    end
    send4(2'd2, 8'h66);
    checks++;
    if (i_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall_ready: i_ready=%b want 0", i_ready4);
    end
    tick();
    checks++;
    if (y_valid4[2] !== 1'b1 || y_data4[23:16] !== 8'h55) begin
      errors++;
      $display("FAIL bp_hold: valid2=%b data2=%h, want 1 55", y_valid4[2], y_data4[23:16]);
    end
    send4(2'd1, 8'h77);
    checks++;
    if (i_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_other_ready: i_ready=%b want 1", i_ready4);
    end
    tick();
    checks++;
    if (y_valid4 !== 4'b0110 || y_data4[15:8] !== 8'h77 || y_data4[23:16] !== 8'h55) begin
      errors++;
      $display("FAIL bp_other: y_valid=%b data1=%h data2=%h, want 0110 77 55",
               y_valid4, y_data4[15:8], y_data4[23:16]);
    end
    y_ready4 = 4'b1111;
    send4(2'd2, 8'h66);
    checks++;
    if (i_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: i_ready=%b want 1", i_ready4);
    end
    tick();
    checks++;
    if (y_valid4 !== 4'b0100 || y_data4[23:16] !== 8'h66) begin
      errors++;
      $display("FAIL bp_no_bubble: y_valid=%b data2=%h, want 0100 66", y_valid4, y_data4[23:16]);
    end
    i_valid4 = 1'b0;
    tick();
    $display("test_back_pressure done y_valid=%b", y_valid4);
  endtask

  task automatic test_simultaneous();
    y_ready4 = 4'b1111;
    send4(2'd0, 8'h5A);
    tick();
    checks++;
    if (y_valid4[0] !== 1'b1 || y_data4[7:0] !== 8'h5A) begin
      errors++;
      $display("FAIL simul_first: valid0=%b data0=%h, want 1 5a", y_valid4[0], y_data4[7:0]);
    end
    send4(2'd0, 8'hC3);
    tick();
    checks++;
    if (y_valid4[0] !== 1'b1 || y_data4[7:0] !== 8'hC3) begin
      errors++;
      $display("FAIL simul_replace: valid0=%b data0=%h, want 1 c3", y_valid4[0], y_data4[7:0]);
    end
    i_valid4 = 1'b0;
    tick();
    checks++;
    if (y_valid4 !== 4'b0000) begin
      errors++;
      $display("FAIL simul_drain: y_valid=%b want 0000", y_valid4);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_drop();
    y_ready3 = 3'b111;
    i_valid3 = 1'b1;
    i_sel3   = 2'd3;
    i_data3  = 8'hEE;
    #1;
    checks++;
    if (i_ready3 !== 1'b1 || o_drop3 !== 1'b0) begin
      errors++;
      $display("FAIL drop_accept: i_ready=%b o_drop=%b, want 1 0", i_ready3, o_drop3);
    end
    tick();
    i_valid3 = 1'b0;
    #1;
    checks++;
    if (o_drop3 !== 1'b1 || y_valid3 !== 3'b000) begin
      errors++;
      $display("FAIL drop_pulse: o_drop=%b y_valid=%b, want 1 000", o_drop3, y_valid3);
    end
    tick();
    checks++;
    if (o_drop3 !== 1'b0) begin
      errors++;
      $display("FAIL drop_one_cycle: o_drop=%b want 0", o_drop3);
    end
    i_valid3 = 1'b1;
    i_sel3   = 2'd2;
    i_data3  = 8'h42;
    tick();
    i_valid3 = 1'b0;
    #1;
    checks++;
    if (y_valid3 !== 3'b100 || y_data3[23:16] !== 8'h42 || o_drop3 !== 1'b0) begin
      errors++;
      $display("FAIL drop_inrange: y_valid=%b data2=%h o_drop=%b, want 100 42 0",
               y_valid3, y_data3[23:16], o_drop3);
    end
    tick();
    $display("test_drop done");
  endtask

  task automatic test_counter();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    y_ready4 = 4'b1111;
`ifdef DEMUX_CNT_EN
    send4(2'd1, 8'h01);
    for (int i = 0; i < 3; i++) tick();
    i_valid4 = 1'b0;
    tick();
    checks++;
    if (o_cnt4[31:16] !== 16'd3 || o_cnt4[15:0] !== 16'd0) begin
      errors++;
      $display("FAIL cnt_small: cnt1=%0d cnt0=%0d, want 3 0", o_cnt4[31:16], o_cnt4[15:0]);
    end
    send4(2'd1, 8'h02);
    for (int i = 0; i < 65534; i++) tick();
    i_valid4 = 1'b0;
    tick();
    checks++;
    if (o_cnt4[31:16] !== 16'd1 || o_cnt4[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL cnt_wrap: cnt1=%0d upper=%h, want 1 0", o_cnt4[31:16], o_cnt4[63:32]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      send4(2'd1, 8'(i));
      tick();
      checks++;
      if (o_cnt4 !== 64'h0 || o_cnt3 !== 48'h0) begin
        errors++;
        $display("FAIL cnt_tied: o_cnt4=%h o_cnt3=%h, want 0", o_cnt4, o_cnt3);
      end
    end
    i_valid4 = 1'b0;
    tick();
`endif
    $display("test_counter done cnt1=%0d", o_cnt4[31:16]);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    i_data4  = 8'h00;
    i_sel4   = 2'd0;
    i_valid4 = 1'b0;
    y_ready4 = 4'b0000;
    i_data3  = 8'h00;
    i_sel3   = 2'd0;
    i_valid3 = 1'b0;
    y_ready3 = 3'b000;
    test_reset();
    test_steering();
    test_back_pressure();
    test_simultaneous();
    test_drop();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
